core_issue_queue: RTL
=====================

// Module: core_issue_queue
// PURPOSE
//  Receive side of the dual-core dispatch interface: captures each instruction steered by the dispatch arbiter
//  (instr_in + fifo1_wr_en/fifo2_wr_en) into one of two per-core FIFOs and issues it to core 1 / core 2
//  over a valid/ready handshake. Sits between the arbiter and the two pipelined cores.
//  Provides full/occupancy backpressure to the arbiter, a flush, and sticky error flags.
// PARAMETERS
//  DATA_W  32  instruction width
//  DEPTH   8   entries per core FIFO; power of two, >=2
//  CNT_W   $clog2(DEPTH)+1  occupancy counter width (derived, localparam)
// PORTS
//  clk           in   1       rising-edge clock
//  resetn        in   1       reset; synchronous, active-low
//  flush         in   1       synchronous clear of both FIFOs (resetn-equivalent for data path; error flags kept)
//  instr_in      in   DATA_W  instruction from arbiter
//  fifo1_wr_en   in   1       push instr_in into core-1 FIFO
//  fifo2_wr_en   in   1       push instr_in into core-2 FIFO
//  fifo1_full    out  1       core-1 FIFO holds DEPTH entries
//  fifo2_full    out  1       core-2 FIFO holds DEPTH entries
//  fifo1_count   out  CNT_W   core-1 occupancy
//  fifo2_count   out  CNT_W   core-2 occupancy
//  core1_instr   out  DATA_W  head of core-1 FIFO
//  core1_valid   out  1       core1_instr valid
//  core1_ready   in   1       core 1 accepts head this cycle
//  core2_instr   out  DATA_W  head of core-2 FIFO
//  core2_valid   out  1       core2_instr valid
//  core2_ready   in   1       core 2 accepts head this cycle
//  err_overflow  out  1       sticky: push attempted while target FIFO full
//  err_dual_wr   out  1       sticky: fifo1_wr_en and fifo2_wr_en both high
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): both FIFOs empty, counts 0, full=0, valid=0, core*_instr=0, err_* =0.
//  - Push: on posedge with wrN_en=1 and FIFO N not full -> entry written at wr_ptr, wr_ptr+1 (mod DEPTH).
//  - Pop: on posedge with coreN_valid && coreN_ready -> rd_ptr+1 (mod DEPTH). Ready without valid ignored.
//  - Issue latency: pushed word visible on coreN_instr with coreN_valid=1 the cycle after the push edge
//    (registered head; no same-cycle write-through).
//  - coreN_instr holds stable while valid && !ready; updates only after a pop or push-into-empty.
//  - When empty, coreN_instr holds last value; verification checks it only when valid=1.
//  - Simultaneous push+pop, FIFO full: pop frees a slot -> push accepted, count unchanged, no overflow.
//  - Simultaneous push+pop, FIFO empty: pop ignored (valid=0); push accepted, count becomes 1.
//  - Push while full with no pop: word dropped, count unchanged, err_overflow set.
//  - Both wr_en high: neither FIFO written, err_dual_wr set (arbiter contract violated).
//  - count = pushes - pops; full = (count==DEPTH); valid = (count!=0). Pointers wrap modulo DEPTH.
//  - flush=1: both FIFOs cleared next edge (counts 0, valid 0); same-cycle push/pop discarded; err_* kept.
//  - resetn takes priority over flush; flush over push/pop. Reset mid-transfer discards all contents.
//  - FIFOs are independent: stall on one core never blocks the other.
// STRUCTURE
//  - issue_pkg: DATA_W, DEPTH defaults; typedef logic [DATA_W-1:0] instr_t; enum core_sel_e {CORE1, CORE2}.
//  - Sub-module issue_fifo (one per core, instantiated twice): storage array, wr/rd pointers, count,
//    full/valid, registered head, overflow pulse. Top adds dual-write check, flush fanout, sticky errors.
// TESTING
//  1. Reset, then push 0xA000_0001..0xA000_0003 to FIFO1, core1_ready=1 -> core1_instr issues in
//     same order, one per cycle from cycle after first push; fifo1_count returns to 0; core2_valid stays 0.
//  2. Push 8 words to FIFO2, core2_ready=0 -> fifo2_full=1, count=8; 9th push 0xDEAD_BEEF dropped,
//     err_overflow=1; release ready -> exactly the 8 original words drain.
//  3. FIFO1 full, same cycle push 0x1111_1111 and pop -> count stays 8, no overflow, 0x1111_1111 issued last.
//  4. fifo1_wr_en=fifo2_wr_en=1 with 0x5555_5555 -> both counts unchanged, err_dual_wr=1.
//  5. FIFO1 holding 5 words, FIFO2 holding 3, assert flush (with concurrent push) -> next cycle counts 0,
//     valids 0, err flags unchanged; subsequent push of 0x0000_00FF issues normally.
//  6. core1_ready=0 with 3 words queued while FIFO2 streams 10 words with core2_ready=1 -> core2 issues all 10
//     unstalled; core1_instr stays at first word throughout.

Source files
------------

// File: rtl/core_issue_queue_pkg.sv
// Shared definitions for the dual-core issue queue.
//   ISSUE_DATA_W / ISSUE_DEPTH : default instruction width and per-core FIFO depth
//   instr_t                    : instruction word at the default width
//   core_sel_e                 : identifies the target core of a dispatch
//   cnt_width()                : width of an occupancy counter able to hold 0..depth
package core_issue_queue_pkg;

    localparam int ISSUE_DATA_W = 32;
    localparam int ISSUE_DEPTH  = 8;

    typedef logic [ISSUE_DATA_W-1:0] instr_t;

    typedef enum logic {
        CORE1 = 1'b0,
        CORE2 = 1'b1
    } core_sel_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/core_issue_queue_if.sv
// Dispatch-side bundle of the dual-core issue queue.
//   master : arbiter/cores side (drives flush, instr_in, wr enables, core readies)
//   slave  : issue queue side (drives full/count, core heads/valids, sticky errors)
interface core_issue_queue_if
    import core_issue_queue_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,
    parameter int DEPTH  = ISSUE_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic              flush;
    logic [DATA_W-1:0] instr_in;
    logic              fifo1_wr_en;
    logic              fifo2_wr_en;
    logic              fifo1_full;
    logic              fifo2_full;
    logic [CNT_W-1:0]  fifo1_count;
    logic [CNT_W-1:0]  fifo2_count;
    logic [DATA_W-1:0] core1_instr;
    logic              core1_valid;
    logic              core1_ready;
    logic [DATA_W-1:0] core2_instr;
    logic              core2_valid;
    logic              core2_ready;
    logic              err_overflow;
    logic              err_dual_wr;

    modport master (
        output flush, instr_in, fifo1_wr_en, fifo2_wr_en, core1_ready, core2_ready,
        input  fifo1_full, fifo2_full, fifo1_count, fifo2_count,
               core1_instr, core1_valid, core2_instr, core2_valid,
               err_overflow, err_dual_wr
    );

    modport slave (
        input  flush, instr_in, fifo1_wr_en, fifo2_wr_en, core1_ready, core2_ready,
        output fifo1_full, fifo2_full, fifo1_count, fifo2_count,
               core1_instr, core1_valid, core2_instr, core2_valid,
               err_overflow, err_dual_wr
    );

endinterface

// File: rtl/core_issue_queue_fifo.sv
// One per-core issue FIFO with a registered head word.
//   clk, resetn : clock, synchronous active-low reset
//   flush       : clears pointers/count next edge, discarding same-cycle push/pop
//   din, push_req : word to enqueue and enqueue request
//   pop_req     : consumer ready; a pop happens only when valid
//   head, valid : registered head word and its valid
//   full, count : occupancy status
//   overflow    : one-cycle pulse when a push is refused because the FIFO is full
module core_issue_queue_fifo
    import core_issue_queue_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,
    parameter int DEPTH  = ISSUE_DEPTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     din,
    input  logic                  push_req,
    input  logic                  pop_req,
    output logic [DATA_W-1:0]     head,
    output logic                  valid,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign valid   = (cnt != '0);
    assign count   = cnt;
    assign rd_next = rd_ptr + PTR_W'(1);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when the head is being consumed.
    assign do_pop   = pop_req && valid;
    assign do_push  = push_req && (!full || do_pop);
    assign overflow = push_req && full && !do_pop && !flush;

    // Storage carries no reset: contents are only observable through head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            // The incoming word becomes the head when it lands in an empty
            // FIFO, or when the only stored entry is popped the same cycle
            // (its successor is being written right now, not yet in mem).
            if (do_push && ((cnt == '0) || (do_pop && cnt == CNT_W'(1)))) begin
                head <= din;
            end else if (do_pop && cnt > CNT_W'(1)) begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/core_issue_queue.sv
// Receive side of the dual-core dispatch interface.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : arbiter pushes (instr_in + fifoN_wr_en), flush, full/count
//                 backpressure, per-core valid/ready issue, sticky errors
// Two independent FIFOs; a stall on one core never affects the other.
module core_issue_queue
    import core_issue_queue_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,
    parameter int DEPTH  = ISSUE_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    core_issue_queue_if.slave bus
);
    logic dual_wr;
    logic ovf1;
    logic ovf2;
    logic err_overflow_q;
    logic err_dual_wr_q;

    // Both enables high violates the arbiter contract: write neither FIFO.
    assign dual_wr = bus.fifo1_wr_en && bus.fifo2_wr_en;

    core_issue_queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (bus.flush),
        .din      (bus.instr_in),
        .push_req (bus.fifo1_wr_en && !dual_wr),
        .pop_req  (bus.core1_ready),
        .head     (bus.core1_instr),
        .valid    (bus.core1_valid),
        .full     (bus.fifo1_full),
        .count    (bus.fifo1_count),
        .overflow (ovf1)
    );

    core_issue_queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo2 (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (bus.flush),
        .din      (bus.instr_in),
        .push_req (bus.fifo2_wr_en && !dual_wr),
        .pop_req  (bus.core2_ready),
        .head     (bus.core2_instr),
        .valid    (bus.core2_valid),
        .full     (bus.fifo2_full),
        .count    (bus.fifo2_count),
        .overflow (ovf2)
    );

    // Sticky error flags survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_overflow_q <= 1'b0;
            err_dual_wr_q  <= 1'b0;
        end else begin
            if (ovf1 || ovf2) begin
                err_overflow_q <= 1'b1;
            end
            if (dual_wr) begin
                err_dual_wr_q <= 1'b1;
            end
        end
    end

    assign bus.err_overflow = err_overflow_q;
    assign bus.err_dual_wr  = err_dual_wr_q;

endmodule
